// File: rtl/regfile_pkg.sv
// Shared sizing and state encoding for registersArray and its dump reader.
package regfile_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned NUM_REGS  = 8;
    localparam int unsigned PAIR_W    = ADDR_W - 1;
    localparam int unsigned NUM_PAIRS = NUM_REGS / 2;

    typedef logic [1:0] dumpState_t;

    localparam dumpState_t ST_IDLE  = 2'd0;
    localparam dumpState_t ST_READ  = 2'd1;
    localparam dumpState_t ST_EMIT0 = 2'd2;
    localparam dumpState_t ST_EMIT1 = 2'd3;

    // True when pair index k holds registers NUM_REGS-2 and NUM_REGS-1.
    function automatic logic isLastPair(input logic [PAIR_W-1:0] k);
        return k == PAIR_W'(NUM_PAIRS - 1);
    endfunction

endpackage

// File: rtl/regfile_dump_pair_buf.sv
// Holds one even/odd register pair captured together and presents one word at a time.
module regfile_dump_pair_buf #(
    parameter int unsigned DataW = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             sel_i,
    input  logic [DataW-1:0] data0_i,
    input  logic [DataW-1:0] data1_i,
    output logic [DataW-1:0] word_o
);

    logic [DataW-1:0] buf0;
    logic [DataW-1:0] buf1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf0 <= '0;
            buf1 <= '0;
        end else if (load_i) begin
            buf0 <= data0_i;
            buf1 <= data1_i;
        end
    end

    assign word_o = sel_i ? buf1 : buf0;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks registersArray two registers per read, streams them with valid/ready, flags overlapping writes.
module regfile_dump_reader
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic              abort_i,
    output logic [ADDR_W-1:0] rd_addr1_o,
    output logic [ADDR_W-1:0] rd_addr2_o,
    input  logic [DATA_W-1:0] rd_data1_i,
    input  logic [DATA_W-1:0] rd_data2_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              stale_o
);

    dumpState_t        state;
    dumpState_t        stateNext;
    logic [PAIR_W-1:0] pairIdx;
    logic [PAIR_W-1:0] pairIdxNext;
    logic              staleFlag;
    logic              staleFlagNext;
    logic              loadPair;
    logic              captureHit;
    logic              selHi;

    logic              selHiNext;
    logic              validNext;
    logic              busyNext;
    logic              doneNext;
    logic              staleNext;
    logic              lastNext;
    logic [ADDR_W-1:0] outAddrNext;
    logic [ADDR_W-1:0] rdAddr1Next;
    logic [ADDR_W-1:0] rdAddr2Next;

    // A write at or below the current pair lands on a register already sampled.
    assign captureHit = wr_en_i && (wr_addr_i[ADDR_W-1:1] <= pairIdx);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            pairIdx     <= '0;
            staleFlag   <= 1'b0;
            selHi       <= 1'b0;
            rd_addr1_o  <= '0;
            rd_addr2_o  <= ADDR_W'(1);
            out_valid_o <= 1'b0;
            out_addr_o  <= '0;
            out_last_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            stale_o     <= 1'b0;
        end else begin
            state       <= stateNext;
            pairIdx     <= pairIdxNext;
            staleFlag   <= staleFlagNext;
            selHi       <= selHiNext;
            rd_addr1_o  <= rdAddr1Next;
            rd_addr2_o  <= rdAddr2Next;
            out_valid_o <= validNext;
            out_addr_o  <= outAddrNext;
            out_last_o  <= lastNext;
            busy_o      <= busyNext;
            done_o      <= doneNext;
            stale_o     <= staleNext;
        end
    end

    always_comb begin
        stateNext     = state;
        pairIdxNext   = pairIdx;
        staleFlagNext = staleFlag;
        loadPair      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    stateNext     = ST_READ;
                    pairIdxNext   = '0;
                    staleFlagNext = 1'b0;
                end
            end
            ST_READ: begin
                loadPair      = 1'b1;
                staleFlagNext = staleFlag | captureHit;
                stateNext     = ST_EMIT0;
            end
            ST_EMIT0: begin
                staleFlagNext = staleFlag | captureHit;
                if (out_ready_i) begin
                    stateNext = ST_EMIT1;
                end
            end
            ST_EMIT1: begin
                staleFlagNext = staleFlag | captureHit;
                if (out_ready_i) begin
                    if (isLastPair(pairIdx)) begin
                        stateNext = ST_IDLE;
                    end else begin
                        pairIdxNext = PAIR_W'(pairIdx + 1'b1);
                        stateNext   = ST_READ;
                    end
                end
            end
            default: stateNext = ST_IDLE;
        endcase
        if (abort_i && (state != ST_IDLE)) begin
            stateNext = ST_IDLE;
        end
    end

    // Registered output values follow the state being entered.
    always_comb begin
        validNext   = (stateNext == ST_EMIT0) || (stateNext == ST_EMIT1);
        busyNext    = stateNext != ST_IDLE;
        selHiNext   = stateNext == ST_EMIT1;
        outAddrNext = {pairIdxNext, stateNext == ST_EMIT1};
        lastNext    = (stateNext == ST_EMIT1) && isLastPair(pairIdxNext);
        rdAddr1Next = {pairIdxNext, 1'b0};
        rdAddr2Next = {pairIdxNext, 1'b1};
        doneNext    = (state == ST_EMIT1) && out_ready_i && isLastPair(pairIdx) && !abort_i;
        staleNext   = doneNext && staleFlagNext;
    end

    regfile_dump_pair_buf #(
        .DataW(DATA_W)
    ) pairBuf (
        .clk    (clk),
        .reset_n(reset_n),
        .load_i (loadPair),
        .sel_i  (selHi),
        .data0_i(rd_data1_i),
        .data1_i(rd_data2_i),
        .word_o (out_data_o)
    );

endmodule
